// File: rtl/cia_tod_gen_pkg.sv
// Shared constants and types for the TOD reference generator.
package cia;

  localparam int CIA_PHI2_PAL_HZ  = 985248;
  localparam int CIA_PHI2_NTSC_HZ = 1022727;
  // Increments are twice the output rate: one accumulator wrap per half period.
  localparam int CIA_TOD_INC_50   = 100;
  localparam int CIA_TOD_INC_60   = 120;

  typedef logic [20:0] tod_acc_t;

endpackage

// File: rtl/cia_tod_gen_frac_div.sv
// Generic Bresenham accumulator: adds inc per step, wraps modulo mod, and
// flags each wrap on carry (combinational, valid in the stepping cycle).
// Assumes inc <= mod and acc < mod, so no intermediate value overflows.
module frac_div
  import cia::*;
(
  input  logic     clk,
  input  logic     res,
  input  logic     clr,
  input  logic     step,
  input  tod_acc_t inc,
  input  tod_acc_t mod,
  output logic     carry
);

  tod_acc_t acc;
  tod_acc_t thr;

  // acc + inc >= mod rewritten as acc >= mod - inc to stay within 21 bits
  assign thr   = mod - inc;
  assign carry = step && !clr && (acc >= thr);

  // Accumulator update: clear has priority over stepping
  always_ff @(posedge clk) begin
    if (res || clr)  acc <= '0;
    else if (step)   acc <= carry ? (acc - thr) : (acc + inc);
  end

endmodule

// File: rtl/cia_tod_gen.sv
// TOD pin generator: synthesises a 50/60 Hz square wave from PHI2 falling
// edges using an exact fractional divider.
// Optional macro CIA_TOD_GEN_TRIM_EN adds a signed 8-bit modulus trim input.
module cia_tod_gen
  import cia::*;
#(
  parameter int PHI2_PAL_HZ  = CIA_PHI2_PAL_HZ,
  parameter int PHI2_NTSC_HZ = CIA_PHI2_NTSC_HZ
) (
  input  logic       clk,
  input  logic       res,
  input  logic       phi2_up,
  input  logic       phi2_dn,
  input  logic       en,
  input  logic       ntsc,
  input  logic       sel60,
`ifdef CIA_TOD_GEN_TRIM_EN
  input  logic [7:0] trim,
`endif
  output logic       tod,
  output logic       tod_tick
);

  logic     en_q, ntsc_q, sel60_q;
  logic     chg, clr, step, carry;
  tod_acc_t inc, mod;
  // The rising PHI2 edge is not needed; everything advances on phi2_dn.
  logic     unused_phi2_up;
  assign unused_phi2_up = phi2_up;

`ifdef CIA_TOD_GEN_TRIM_EN
  logic [7:0] trim_q;
  assign chg = (ntsc != ntsc_q) || (sel60 != sel60_q) || (trim != trim_q);
  assign mod = (ntsc ? tod_acc_t'(PHI2_NTSC_HZ) : tod_acc_t'(PHI2_PAL_HZ))
             + {{13{trim[7]}}, trim};
`else
  assign chg = (ntsc != ntsc_q) || (sel60 != sel60_q);
  assign mod = ntsc ? tod_acc_t'(PHI2_NTSC_HZ) : tod_acc_t'(PHI2_PAL_HZ);
`endif

  // inc/mod follow the live inputs: a step only happens when they match the
  // registered copies, or on the enabling strobe where the copies load fresh.
  assign inc  = sel60 ? tod_acc_t'(CIA_TOD_INC_60) : tod_acc_t'(CIA_TOD_INC_50);
  assign clr  = phi2_dn && (!en || (en_q && chg));
  assign step = phi2_dn && en && !(en_q && chg);

  frac_div u_div (
    .clk   (clk),
    .res   (res),
    .clr   (clr),
    .step  (step),
    .inc   (inc),
    .mod   (mod),
    .carry (carry)
  );

  // Settings copies, enable tracking, tod toggle and rising-edge tick
  always_ff @(posedge clk) begin
    if (res) begin
      en_q     <= 1'b0;
      ntsc_q   <= 1'b0;
      sel60_q  <= 1'b0;
`ifdef CIA_TOD_GEN_TRIM_EN
      trim_q   <= '0;
`endif
      tod      <= 1'b0;
      tod_tick <= 1'b0;
    end else begin
      tod_tick <= 1'b0;
      if (phi2_dn) begin
        en_q    <= en;
        ntsc_q  <= ntsc;
        sel60_q <= sel60;
`ifdef CIA_TOD_GEN_TRIM_EN
        trim_q  <= trim;
`endif
        if (!en) begin
          tod <= 1'b0;
        end else if (carry) begin
          tod      <= ~tod;
          tod_tick <= ~tod;
        end
      end
    end
  end

endmodule
